// File: rtl/xc20xx_clbse_pkg.sv
// Shared encodings for the XC20XX CLB storage-element bank: config byte layout,
// mux select codes, mode codes and the load/run state machine encoding.
package xc20xx_clbse_pkg;

    localparam int CFG_BITS_PER_CH = 8;

    localparam int S_SEL_LSB  = 0;
    localparam int R_SEL_LSB  = 2;
    localparam int CE_SEL_LSB = 4;
    localparam int CE_POL_BIT = 6;
    localparam int MODE_BIT   = 7;

    localparam logic [1:0] S_SEL_A = 2'b00;
    localparam logic [1:0] S_SEL_F = 2'b01;

    localparam logic [1:0] R_SEL_D = 2'b00;
    localparam logic [1:0] R_SEL_G = 2'b01;

    localparam logic [1:0] CE_SEL_ALWAYS = 2'b00;
    localparam logic [1:0] CE_SEL_C      = 2'b01;
    localparam logic [1:0] CE_SEL_G      = 2'b10;
    localparam logic [1:0] CE_SEL_NEVER  = 2'b11;

    localparam logic MODE_DFF    = 1'b0;
    localparam logic MODE_TOGGLE = 1'b1;

    // Field order matches the byte layout, MSB first.
    typedef struct packed {
        logic       mode;
        logic       ce_pol;
        logic [1:0] ce_sel;
        logic [1:0] r_sel;
        logic [1:0] s_sel;
    } cfg_t;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/xc20xx_clbse_cell.sv
// One storage channel: R/S/enable/mode selection from its config byte, 1-cycle latency,
// holds its output whenever freeze_i is high (bank is loading configuration).
module xc20xx_clbse_cell
    import xc20xx_clbse_pkg::*;
(
    input  logic       k_i,
    input  logic       rst_n_i,
    input  logic       freeze_i,
    input  logic [7:0] cfg_i,
    input  logic       a_i,
    input  logic       c_i,
    input  logic       d_i,
    input  logic       f_i,
    input  logic       g_i,
    output logic       q_o
);

    cfg_t cfg;
    logic s_act;
    logic r_act;
    logic en_act;
    logic q_d;
    logic q_q;

    assign cfg = cfg_t'(cfg_i);

    always_comb begin
        s_act = 1'b0;
        case (cfg.s_sel)
            S_SEL_A: s_act = a_i;
            S_SEL_F: s_act = f_i;
            default: s_act = 1'b0;
        endcase

        r_act = 1'b0;
        case (cfg.r_sel)
            R_SEL_D: r_act = d_i;
            R_SEL_G: r_act = g_i;
            default: r_act = 1'b0;
        endcase

        en_act = 1'b0;
        case (cfg.ce_sel)
            CE_SEL_ALWAYS: en_act = 1'b1;
            CE_SEL_C:      en_act = c_i ^ cfg.ce_pol;
            CE_SEL_G:      en_act = g_i ^ cfg.ce_pol;
            default:       en_act = 1'b0;
        endcase

        // Reset beats R beats S beats enable.
        q_d = q_q;
        if (r_act) begin
            q_d = 1'b0;
        end else if (s_act) begin
            q_d = 1'b1;
        end else if (en_act) begin
            q_d = (cfg.mode == MODE_TOGGLE) ? (q_q ^ f_i) : f_i;
        end
    end

    always_ff @(posedge k_i) begin
        if (!rst_n_i) begin
            q_q <= 1'b0;
        end else if (!freeze_i) begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/xc20xx_clbse_array.sv
// Bank of WIDTH CLB storage elements with a serial configuration chain.
// Q latency 1 cycle; all storage freezes while a configuration load is in progress.
module xc20xx_clbse_array
    import xc20xx_clbse_pkg::*;
#(
    parameter int                       WIDTH    = 4,
    parameter logic [8*WIDTH-1:0]       CFG_INIT = '0
) (
    input  logic             K,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] F,
    input  logic [WIDTH-1:0] G,
    input  logic             CFG_EN,
    input  logic             CFG_DIN,
    output logic             CFG_DOUT,
    output logic             CFG_DONE,
    output logic [WIDTH-1:0] Q
);

    localparam int CHAIN_W = CFG_BITS_PER_CH * WIDTH;
    localparam int CNT_W   = $clog2(CHAIN_W + 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_W - 1);

    state_e             state_q;
    logic [CHAIN_W-1:0] chain_q;
    logic [CHAIN_W-1:0] chain_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               done_q;
    logic               freeze;
    logic [CHAIN_W-1:0] cell_cfg;

    assign chain_d = {chain_q[CHAIN_W-2:0], CFG_DIN};
    assign cnt_d   = cnt_q + ONE_CNT;

    // cnt_q counts bits already shifted; the edge that shifts bit CHAIN_W ends the load.
    always_ff @(posedge K) begin
        if (!RST_N) begin
            state_q <= ST_RUN;
            chain_q <= CFG_INIT;
            cnt_q   <= '0;
            done_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (CFG_EN) begin
                        state_q <= ST_LOAD;
                        chain_q <= chain_d;
                        cnt_q   <= ONE_CNT;
                        done_q  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (CFG_EN) begin
                        chain_q <= chain_d;
                        if (cnt_q == LAST_CNT) begin
                            state_q <= ST_RUN;
                            cnt_q   <= '0;
                            done_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                    cnt_q   <= '0;
                    done_q  <= 1'b1;
                end
            endcase
        end
    end

    assign freeze   = (state_q != ST_RUN);
    // A half-shifted chain is never presented to the channels.
    assign cell_cfg = freeze ? '0 : chain_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        xc20xx_clbse_cell u_cell (
            .k_i      (K),
            .rst_n_i  (RST_N),
            .freeze_i (freeze),
            .cfg_i    (cell_cfg[CFG_BITS_PER_CH*i +: CFG_BITS_PER_CH]),
            .a_i      (A[i]),
            .c_i      (C[i]),
            .d_i      (D[i]),
            .f_i      (F[i]),
            .g_i      (G[i]),
            .q_o      (Q[i])
        );
    end

    assign CFG_DOUT = chain_q[CHAIN_W-1];
    assign CFG_DONE = done_q;

endmodule

// File: tb/tb_xc20xx_clbse_array.sv
// Directed + randomized bench for xc20xx_clbse_array against a behavioural bank model.
module tb_xc20xx_clbse_array;

    localparam int W  = 4;
    localparam int CW = 8 * W;
    localparam logic [CW-1:0] INIT = '0;

    logic          K = 1'b0;
    logic          RST_N;
    logic [W-1:0]  A, C, D, F, G;
    logic          CFG_EN, CFG_DIN;
    logic          CFG_DOUT, CFG_DONE;
    logic [W-1:0]  Q;

    int checks = 0;
    int errors = 0;

    // Behavioural model of the bank.
    logic [CW-1:0] m_chain = '0;
    bit            m_load  = 1'b0;
    int            m_cnt   = 0;
    logic [W-1:0]  m_q     = '0;

    xc20xx_clbse_array #(.WIDTH(W), .CFG_INIT(INIT)) dut (
        .K        (K),
        .RST_N    (RST_N),
        .A        (A),
        .C        (C),
        .D        (D),
        .F        (F),
        .G        (G),
        .CFG_EN   (CFG_EN),
        .CFG_DIN  (CFG_DIN),
        .CFG_DOUT (CFG_DOUT),
        .CFG_DONE (CFG_DONE),
        .Q        (Q)
    );

    always #5 K = ~K;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Next value of one channel, read straight from the config byte fields.
    function automatic logic ch_next(input int i, input logic [CW-1:0] chain, input logic q);
        int b, s_sel, r_sel, ce_sel, pol, mode;
        logic s, r, en;
        b      = int'((chain >> (8 * i)) & 'hFF);
        s_sel  = b % 4;
        r_sel  = (b / 4) % 4;
        ce_sel = (b / 16) % 4;
        pol    = (b / 64) % 2;
        mode   = b / 128;
        s  = (s_sel == 0) ? A[i] : (s_sel == 1) ? F[i] : 1'b0;
        r  = (r_sel == 0) ? D[i] : (r_sel == 1) ? G[i] : 1'b0;
        en = (ce_sel == 0) ? 1'b1 :
             (ce_sel == 1) ? (C[i] ^ pol[0]) :
             (ce_sel == 2) ? (G[i] ^ pol[0]) : 1'b0;
        if (r)   return 1'b0;
        if (s)   return 1'b1;
        if (!en) return q;
        return (mode == 1) ? (q ^ F[i]) : F[i];
    endfunction

    task automatic tick();
        logic [CW-1:0] nchain;
        bit            nload;
        int            ncnt;
        logic [W-1:0]  nq;
        nchain = m_chain; nload = m_load; ncnt = m_cnt; nq = m_q;
        if (!RST_N) begin
            nchain = INIT; nload = 1'b0; ncnt = 0; nq = '0;
        end else begin
            if (!m_load)
                for (int i = 0; i < W; i++) nq[i] = ch_next(i, m_chain, m_q[i]);
            if (CFG_EN) begin
                nchain = {m_chain[CW-2:0], CFG_DIN};
                if (!m_load) begin
                    nload = 1'b1; ncnt = 1;
                end else if (m_cnt + 1 == CW) begin
                    nload = 1'b0; ncnt = 0;
                end else begin
                    ncnt = m_cnt + 1;
                end
            end
        end
        @(posedge K);
        #1;
        m_chain = nchain; m_load = nload; m_cnt = ncnt; m_q = nq;
        check("q", Q, m_q);
        check("cfg_done", CFG_DONE, !m_load);
        check("cfg_dout", CFG_DOUT, m_chain[CW-1]);
    endtask

    task automatic rand_data();
        A = W'($urandom); C = W'($urandom); D = W'($urandom);
        F = W'($urandom); G = W'($urandom);
    endtask

    task automatic run_random(input int n);
        CFG_EN = 1'b0;
        for (int k = 0; k < n; k++) begin
            rand_data();
            tick();
        end
    endtask

    // Shift a word MSB-first; optionally pause CFG_EN before bit pause_at.
    task automatic load_word(input logic [CW-1:0] word, input int pause_at,
                             input int pause_len, input string tag);
        logic [CW-1:0] old;
        int edges, first_done;
        old = m_chain; edges = 0; first_done = 0;
        for (int b = 0; b < CW; b++) begin
            if (b == pause_at) begin
                for (int p = 0; p < pause_len; p++) begin
                    CFG_EN = 1'b0;
                    rand_data();
                    tick();
                    edges++;
                    if (first_done == 0 && CFG_DONE === 1'b1) first_done = edges;
                end
            end
            check({tag, "_shift_out"}, CFG_DOUT, old[CW-1-b]);
            CFG_EN  = 1'b1;
            CFG_DIN = word[CW-1-b];
            rand_data();
            tick();
            edges++;
            if (first_done == 0 && CFG_DONE === 1'b1) first_done = edges;
        end
        CFG_EN = 1'b0;
        check({tag, "_load_cycles"}, first_done, CW + pause_len);
    endtask

    initial begin
        logic [W-1:0]  prev;
        logic [CW-1:0] saved;

        RST_N = 1'b0; CFG_EN = 1'b0; CFG_DIN = 1'b0;
        A = '0; C = '0; D = '0; F = '0; G = '0;
        tick();
        tick();
        check("reset_q", Q, '0);
        check("reset_done", CFG_DONE, 1'b1);

        // Default config: S=A, R=D, always enabled, DFF.
        RST_N = 1'b1;
        F = 4'b1010;
        check("pre_edge_q", Q, '0);
        tick();
        check("default_dff", Q, 4'b1010);
        run_random(16);

        // TOGGLE, CE=C inverted, S=R=none in every channel.
        load_word(32'hDADA_DADA, -1, 0, "full");
        A = W'($urandom); D = W'($urandom); G = W'($urandom);
        F = 4'hF; C = 4'h0;
        for (int k = 0; k < 4; k++) begin
            prev = m_q;
            tick();
            check("toggle", Q, prev ^ 4'hF);
        end
        C = 4'hF;
        for (int k = 0; k < 3; k++) begin
            prev = m_q;
            tick();
            check("ce_hold", Q, prev);
        end

        load_word(W'($urandom) == 0 ? 32'h1234_5678 : $urandom, 10, 5, "paused");
        run_random(12);
        for (int r = 0; r < 3; r++) begin
            load_word($urandom, -1, 0, "rnd");
            run_random(16);
        end

        // S/R collision with S=A, R=D.
        load_word('0, -1, 0, "zero_cfg");
        A = 4'hF; D = 4'hF; F = W'($urandom);
        tick();
        check("sr_collision", Q, 4'h0);
        D = 4'h0;
        tick();
        check("sr_set", Q, 4'hF);

        // Daisy chain: eight more bits push out the old MSBs in order.
        load_word(32'hA5C3_96F0, -1, 0, "pattern");
        saved = m_chain;
        for (int k = 0; k < 8; k++) begin
            check("daisy_dout", CFG_DOUT, saved[CW-1-k]);
            CFG_EN = 1'b1; CFG_DIN = 1'($urandom);
            tick();
        end

        // Storage frozen mid-load, then reset aborts the load.
        CFG_EN = 1'b0;
        prev = m_q;
        for (int k = 0; k < 6; k++) begin
            A = W'($urandom); D = W'($urandom); F = W'($urandom);
            tick();
            check("freeze_q", Q, prev);
        end
        RST_N = 1'b0;
        tick();
        check("abort_q", Q, '0);
        check("abort_done", CFG_DONE, 1'b1);
        RST_N = 1'b1;
        load_word($urandom, -1, 0, "post_abort");
        run_random(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
